dct_2d_seq_ctrl: RTL and testbench
==================================

// Module: dct_2d_seq_ctrl
// PURPOSE
//  Sequences one shared combinational 8-point 1D DCT unit to compute an 8x8 2D DCT.
//  Row pass: accepts 8 pixel rows and sends each through the 1D unit, storing results in a transpose buffer.
//  Column pass: sends the 8 buffer columns through the same unit and streams the 8 results out with backpressure.
//  Sits between the pixel-row source and the downstream quantiser/packer; the 1D unit is instantiated by the parent.
// PARAMETERS
//  ELEM_W  8  element width in bits; only 8 is supported.
//  N       8  points per 1D transform and rows/cols per block; only 8 is supported.
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   reset: asynchronous, active-high
//  in_valid   in   1   in_row is valid
//  in_ready   out  1   controller accepts a row this cycle
//  in_row     in   64  one row, 8 x 8-bit; element 0 in [63:56], element 7 in [7:0]
//  dct_in     out  64  operand to the 1D DCT unit (same byte order)
//  dct_out    in   64  combinational result from the 1D DCT unit; z0 in [63:56]
//  out_valid  out  1   out_col is valid
//  out_ready  in   1   downstream accepts out_col
//  out_col    out  64  column-pass result for column out_idx
//  out_idx    out  3   column index of out_col
//  out_last   out  1   high with out_valid when out_idx==7
//  busy       out  1   high in any state other than ROW with row count 0
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, out_col=0, out_idx=0, out_last=0, busy=0.
//    FSM=ROW, row_cnt=0, col_cnt=0. The transpose buffer is not reset; it is don't-care until written.
//  The first cycle after reset deasserts has in_ready=1.
//  FSM states:
//    ROW:   in_ready=1; dct_in=in_row.
//           On in_valid&&in_ready: buf[row_cnt]<=dct_out (same cycle, zero added latency); row_cnt++.
//           Accepting row 7 -> COL with col_cnt=0.
//    COL:   in_ready=0; dct_in=column col_cnt of buf = {buf[0].b[c],buf[1].b[c],...,buf[7].b[c]}, buf[0] in [63:56].
//           Byte b[c] of a row is bits [63-8c -: 8].
//           Load condition: !out_valid || out_ready.
//           On load: out_col<=dct_out, out_idx<=col_cnt, out_last<=(col_cnt==7), out_valid<=1, col_cnt++.
//           Loading col 7 -> DRAIN.
//    DRAIN: in_ready=0; dct_in=0. On out_valid&&out_ready: out_valid<=0 -> ROW, row_cnt=0.
//  Output handshake:
//    out_valid/out_col/out_idx/out_last hold stable while out_valid && !out_ready.
//    Back-to-back output is allowed: one column per cycle when out_ready is held at 1.
//    A column-pass block therefore takes 8 cycles plus the DRAIN handshake.
//  in_valid while in_ready=0 is ignored (no accept, no state change). The source must hold the row.
//  dct_in=0 in DRAIN and whenever the FSM is not driving an operand. It never carries X.
//  Arithmetic: the controller does no arithmetic on data; bytes pass through the buffer unmodified.
//    The column pass reuses the row-pass result bytes as raw 8-bit operands.
//  Counters are 3 bits; wrap 7->0 only at the state transitions above. There is no other wrap path.
//  Reset mid-block: async clear to the reset values; the partial block is discarded and the next row accepted is row 0.
//  out_ready while out_valid=0 has no effect.
// STRUCTURE
//  Shared package dct_pkg: state enum {ROW,COL,DRAIN}, localparams ELEM_W=8, N=8, ROW_W=64, and a byte-select function.
//  Sub-module dct_transpose_buf (8x64 registers):
//    Write port: whole row, indexed by row_cnt.
//    Read port: whole column, indexed by col_cnt, combinational.
//  Top: FSM, counters, output register, dct_in mux.
// TESTING
//  T1: rows all 0x80, out_ready=1 -> out_col[0]=64'h0F00_0000_0000_0000, out_col[1..7]=0, out_last on idx 7.
//  T2: all-zero rows -> 8 outputs of 0, out_idx 0..7 in order, in_ready=0 from accept of row 7 until after DRAIN.
//  T3: T1 with out_ready toggled 1,0,0,1,... -> same 8 values in order, payload stable during stalls, no drop or duplicate.
//  T4: rst pulsed after 5 rows, then 8 rows of 0x80 -> output identical to T1 (partial block discarded).
//  T5: in_valid held 1 during COL/DRAIN with row 0xFF.. -> no rows accepted until back in ROW; T1 result unaffected.
//  T6: two consecutive T1 blocks, out_ready=1 -> second block identical; first row of block 2 accepted on the cycle after DRAIN.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 2D DCT sequencer.
// Byte 0 of a row or column is the most significant byte.
package dct_pkg;
   localparam int ELEM_W = 8;
   localparam int N      = 8;
   localparam int ROW_W  = ELEM_W * N;

   typedef enum logic [1:0] {ROW, COL, DRAIN} state_t;

   function automatic logic [ELEM_W-1:0] get_byte(input logic [ROW_W-1:0] row,
                                                  input logic [2:0]       idx);
      return row[ROW_W-1-ELEM_W*int'(idx) -: ELEM_W];
   endfunction
endpackage

// File: rtl/dct_transpose_buf.sv
// 8x64 transpose store: whole-row write, combinational whole-column read.
// Write lands on the clock edge; read has zero latency; no backpressure.
module dct_transpose_buf
   import dct_pkg::*;
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [2:0]       wr_idx,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [2:0]       rd_idx,
   output logic [ROW_W-1:0] rd_col
);
   logic [ROW_W-1:0] mem [N];

   // Contents are don't-care until written, so there is no reset here.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_row;
   end

   always_comb begin
      rd_col = '0;
      for (int r = 0; r < N; r++)
         rd_col[ROW_W-1-ELEM_W*r -: ELEM_W] = get_byte(mem[r], rd_idx);
   end
endmodule

// File: rtl/dct_2d_seq_ctrl.sv
// Sequences a shared 1D DCT over 8 rows then 8 transposed columns into an 8x8 2D DCT.
// Rows take 1 cycle each; columns stream 1/cycle through a registered output that stalls on !out_ready.
module dct_2d_seq_ctrl #(
   parameter int ELEM_W = 8,
   parameter int N      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ELEM_W*N-1:0] in_row,
   output logic [ELEM_W*N-1:0] dct_in,
   input  logic [ELEM_W*N-1:0] dct_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ELEM_W*N-1:0] out_col,
   output logic [2:0]          out_idx,
   output logic                out_last,
   output logic                busy
);
   dct_pkg::state_t     st;
   logic [2:0]          row_cnt;
   logic [2:0]          col_cnt;
   logic [ELEM_W*N-1:0] col_dat;
   logic                row_wr;
   logic                col_load;

   // Held low during reset so nothing is offered before the FSM is live.
   assign in_ready = (st == dct_pkg::ROW) && !rst;
   assign busy     = !((st == dct_pkg::ROW) && (row_cnt == 3'd0));
   assign row_wr   = (st == dct_pkg::ROW) && in_valid;
   assign col_load = (st == dct_pkg::COL) && (!out_valid || out_ready);

   dct_transpose_buf u_buf (
      .clk    (clk),
      .wr_en  (row_wr),
      .wr_idx (row_cnt),
      .wr_row (dct_out),
      .rd_idx (col_cnt),
      .rd_col (col_dat)
   );

   always_comb begin
      dct_in = '0;
      case (st)
         dct_pkg::ROW: dct_in = in_row;
         dct_pkg::COL: dct_in = col_dat;
         default:      dct_in = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= dct_pkg::ROW;
         row_cnt   <= 3'd0;
         col_cnt   <= 3'd0;
         out_valid <= 1'b0;
         out_col   <= '0;
         out_idx   <= 3'd0;
         out_last  <= 1'b0;
      end else begin
         case (st)
            dct_pkg::ROW: begin
               if (in_valid) begin
                  row_cnt <= row_cnt + 3'd1;
                  if (row_cnt == 3'd7) begin
                     st      <= dct_pkg::COL;
                     col_cnt <= 3'd0;
                  end
               end
            end
            dct_pkg::COL: begin
               if (col_load) begin
                  out_col   <= dct_out;
                  out_idx   <= col_cnt;
                  out_last  <= (col_cnt == 3'd7);
                  out_valid <= 1'b1;
                  col_cnt   <= col_cnt + 3'd1;
                  if (col_cnt == 3'd7)
                     st <= dct_pkg::DRAIN;
               end
            end
            dct_pkg::DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  st        <= dct_pkg::ROW;
                  row_cnt   <= 3'd0;
               end
            end
            default: st <= dct_pkg::ROW;
         endcase
      end
   end
endmodule

// File: tb/tb_dct_2d_seq_ctrl.sv
// Bench for dct_2d_seq_ctrl with a stand-in 1D transform and a block-level scoreboard.
// Stand-in: DC = (11*sum)>>8, AC k = x[k]-x[k-1]; constant 0x80 block yields DC 0x0F.
module tb_dct_2d_seq_ctrl;
   typedef logic [63:0] blk_t [8];
   typedef struct {
      logic [63:0] col;
      logic [2:0]  idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_row;
   logic [63:0] dct_in;
   logic [63:0] dct_out;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_col;
   logic [2:0]  out_idx;
   logic        out_last;
   logic        busy;

   int   total = 0;
   int   bad   = 0;
   int   rdy_mode = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   dct_2d_seq_ctrl #(.ELEM_W(8), .N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .dct_in    (dct_in),
      .dct_out   (dct_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   function automatic logic [7:0] byte_of(input logic [63:0] w, input int k);
      return w[63-8*k -: 8];
   endfunction

   function automatic logic [63:0] dct_stub(input logic [63:0] x);
      int          sum;
      logic [63:0] z;
      sum = 0;
      z   = '0;
      for (int k = 0; k < 8; k++) sum += int'(byte_of(x, k));
      z[63:56] = 8'((sum * 11) >> 8);
      for (int k = 1; k < 8; k++) z[63-8*k -: 8] = byte_of(x, k) - byte_of(x, k-1);
      return z;
   endfunction

   assign dct_out = dct_stub(dct_in);

   // 2D result: transform rows, transpose as a matrix, transform columns.
   function automatic blk_t ref_block(input blk_t rows);
      blk_t        r1;
      blk_t        res;
      logic [63:0] col;
      for (int r = 0; r < 8; r++) r1[r] = dct_stub(rows[r]);
      for (int c = 0; c < 8; c++) begin
         col = '0;
         for (int r = 0; r < 8; r++) col[63-8*r -: 8] = byte_of(r1[r], c);
         res[c] = dct_stub(col);
      end
      return res;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input blk_t v);
      for (int c = 0; c < 8; c++) exp_q.push_back('{col: v[c], idx: 3'(c)});
   endtask

   task automatic send_rows(input blk_t rows, input int n, input bit gaps, input bit hold_after);
      for (int r = 0; r < n; r++) begin
         bit acc;
         acc = 1'b0;
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_row   = rows[r];
         for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
         end
         if (!acc) chk("row_accept_timeout", 64'd0, 64'd1);
      end
      if (hold_after) in_row = 64'hFFFF_FFFF_FFFF_FFFF;
      else            in_valid = 1'b0;
   endtask

   task automatic wait_drain(input bit drop_valid);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         done = out_valid && out_ready && out_last;
         @(posedge clk);
         #1;
      end
      if (!done) chk("drain_timeout", 64'd0, 64'd1);
      if (drop_valid) in_valid = 1'b0;
   endtask

   initial begin
      int k = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (k % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         k++;
      end
   end

   // Output scoreboard, stall stability and in_ready-during-block checks.
   initial begin
      int          rows_seen = 0;
      bit          lock = 1'b0;
      bit          ready_next = 1'b0;
      bit          stall = 1'b0;
      logic [63:0] stall_col = '0;
      logic [2:0]  stall_idx = '0;
      logic        stall_last = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            rows_seen  = 0;
            lock       = 1'b0;
            ready_next = 1'b0;
            stall      = 1'b0;
         end else begin
            if (ready_next) begin
               chk("ready_after_drain", 64'(in_ready), 64'd1);
               ready_next = 1'b0;
            end
            if (lock) chk("ready_low_in_block", 64'(in_ready), 64'd0);
            if (stall) begin
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_col", out_col, stall_col);
               chk("stall_idx", 64'(out_idx), 64'(stall_idx));
               chk("stall_last", 64'(out_last), 64'(stall_last));
            end
            stall      = out_valid && !out_ready;
            stall_col  = out_col;
            stall_idx  = out_idx;
            stall_last = out_last;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_out", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_col", out_col, e.col);
                  chk("out_idx", 64'(out_idx), 64'(e.idx));
                  chk("out_last", 64'(out_last), 64'(e.idx == 3'd7));
               end
               if (out_last) begin
                  lock       = 1'b0;
                  ready_next = 1'b1;
               end
            end
            if (in_valid && in_ready) begin
               rows_seen++;
               if (rows_seen == 8) begin
                  rows_seen = 0;
                  lock      = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      blk_t b80;
      blk_t bz;
      blk_t e80;
      blk_t rnd;
      for (int r = 0; r < 8; r++) begin
         b80[r] = 64'h8080_8080_8080_8080;
         bz[r]  = 64'd0;
         e80[r] = 64'd0;
      end
      e80[0] = 64'h0F00_0000_0000_0000;

      rst      = 1'b0;
      in_valid = 1'b0;
      in_row   = 64'd0;
      #1 rst   = 1'b1;
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_col", out_col, 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_first_cycle", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Constant 0x80 block, zero block, then the 0x80 block under a 1,0,0 ready pattern.
      rdy_mode = 0;
      push_exp(e80); send_rows(b80, 8, 1'b0, 1'b0); wait_drain(1'b0);
      push_exp(bz);  send_rows(bz, 8, 1'b0, 1'b0);  wait_drain(1'b0);
      rdy_mode = 1;
      push_exp(e80); send_rows(b80, 8, 1'b0, 1'b0); wait_drain(1'b0);

      // Reset in the middle of a block discards the partial rows.
      rdy_mode = 0;
      for (int r = 0; r < 8; r++) rnd[r] = {$urandom, $urandom};
      send_rows(rnd, 5, 1'b0, 1'b0);
      @(negedge clk);
      chk("busy_mid_block", 64'(busy), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      push_exp(e80); send_rows(b80, 8, 1'b0, 1'b0); wait_drain(1'b0);

      // in_valid held high with 0xFF rows through COL and DRAIN.
      push_exp(e80); send_rows(b80, 8, 1'b0, 1'b1); wait_drain(1'b1);
      push_exp(e80); send_rows(b80, 8, 1'b0, 1'b0); wait_drain(1'b0);

      // Two blocks back to back; the second block's first row waits for ROW.
      push_exp(e80); push_exp(e80);
      send_rows(b80, 8, 1'b0, 1'b0);
      send_rows(b80, 8, 1'b0, 1'b0);
      wait_drain(1'b0);

      // Random blocks, random gaps on the input, random ready on the output.
      rdy_mode = 2;
      for (int b = 0; b < 6; b++) begin
         for (int r = 0; r < 8; r++) rnd[r] = {$urandom, $urandom};
         push_exp(ref_block(rnd));
         send_rows(rnd, 8, 1'b1, 1'b0);
         wait_drain(1'b0);
      end

      repeat (3) @(posedge clk);
      chk("exp_left", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
